// File: rtl/dcache_assoc.sv
// Set-associative write-back data cache with tree-PLRU replacement, an uncached
// bypass path and a full-cache flush walk. Metadata lives in registers so reset clears it in one edge.
package dcache_pkg;
  localparam logic [2:0] MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3;
  localparam logic [3:0] MLEN1 = 4'd0, MLEN16 = 4'd15;
  localparam logic [1:0] BURST_FIXED = 2'd0, BURST_INCR = 2'd1;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

// state      | meaning
// IDLE       | accepting a CPU request or a flush
// LOOKUP     | tag compare; hit answers, miss picks a victim
// WRITEBACK  | dirty victim burst to memory
// REFILL     | missed line burst from memory
// UNCACHED   | single-beat bypass access
// FLUSH_SCAN | visit one (set, way) per cycle, invalidating it
// FLUSH_WB   | write back the dirty line found by the scan
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 16,
  parameter int WAYS           = 4,
  parameter int SETS           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  input  logic       flush_req,
  output logic       flush_done
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - 3 - OW - IW;
  localparam int LW = $clog2(WAYS);
  localparam int WW = (WAYS > 1) ? LW : 1;
  localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, REFILL, UNCACHED, FLUSH_SCAN, FLUSH_WB
  } state_t;

  state_t state;

  logic [63:0]     data_mem [SETS][WAYS][WORDS_PER_LINE];
  logic [TW-1:0]   tag_mem  [SETS][WAYS];
  logic [WAYS-1:0] valid_q  [SETS];
  logic [WAYS-1:0] dirty_q  [SETS];
  logic [PW-1:0]   plru_q   [SETS];

  logic [31:0]   req_addr;
  logic [2:0]    req_size;
  logic [7:0]    req_strobe;
  logic [63:0]   req_data;
  logic [OW-1:0] beat;
  logic [IW-1:0] wb_set, fl_set, fl_set_nx;
  logic [WW-1:0] wb_way, fl_way, fl_way_nx, victim_q;
  logic          flush_done_q;

  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_set;
  logic [OW-1:0] req_off;
  logic          hit, has_inv, fl_last;
  logic [WW-1:0] hit_way, inv_way, victim;

  assign req_tag = req_addr[31 -: TW];
  assign req_set = req_addr[3 + OW +: IW];
  assign req_off = req_addr[3 +: OW];

  // Heap-ordered tree: node n (1-based) stored at bit n-1; a 0 bit points left.
  function automatic logic [WW-1:0] plru_victim(input logic [PW-1:0] bits);
    int node;
    node = 1;
    for (int l = 0; l < LW; l++) node = 2 * node + int'(bits[node-1]);
    return WW'(node - WAYS);
  endfunction

  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] bits, input logic [WW-1:0] way);
    logic [PW-1:0] b;
    int node;
    b = bits;
    node = 1;
    for (int l = 0; l < LW; l++) begin
      b[node-1] = ~way[LW-1-l];
      node = 2 * node + int'(way[LW-1-l]);
    end
    return b;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_set][w] && tag_mem[req_set][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_set][w]) begin
        has_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
    victim = has_inv ? inv_way : plru_victim(plru_q[req_set]);
  end

  always_comb begin
    fl_last   = (fl_set == IW'(SETS - 1)) && (fl_way == WW'(WAYS - 1));
    fl_set_nx = fl_set;
    fl_way_nx = fl_way + 1'b1;
    if (fl_way == WW'(WAYS - 1)) begin
      fl_way_nx = '0;
      fl_set_nx = fl_set + 1'b1;
    end
  end

  always_comb begin
    creq = '0;
    case (state)
      WRITEBACK, FLUSH_WB: begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.size     = MSIZE8;
        creq.addr     = {tag_mem[wb_set][wb_way], wb_set, {(OW + 3){1'b0}}};
        creq.strobe   = 8'hFF;
        creq.data     = data_mem[wb_set][wb_way][beat];
        creq.len      = 4'(WORDS_PER_LINE - 1);
        creq.burst    = BURST_INCR;
      end
      REFILL: begin
        creq.valid = 1'b1;
        creq.size  = MSIZE8;
        creq.addr  = {req_tag, req_set, {(OW + 3){1'b0}}};
        creq.len   = 4'(WORDS_PER_LINE - 1);
        creq.burst = BURST_INCR;
      end
      UNCACHED: begin
        creq.valid    = 1'b1;
        creq.is_write = |req_strobe;
        creq.size     = req_size;
        creq.addr     = req_addr;
        creq.strobe   = req_strobe;
        creq.data     = req_data;
        creq.len      = MLEN1;
        creq.burst    = BURST_FIXED;
      end
      default: ;
    endcase
    if (reset) creq.valid = 1'b0;
  end

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = (state == IDLE) && !reset;
    if (state == LOOKUP && hit) begin
      dresp.data_ok = 1'b1;
      dresp.data    = data_mem[req_set][hit_way][req_off];
    end else if (state == UNCACHED && cresp.ready && cresp.last) begin
      dresp.data_ok = 1'b1;
      dresp.data    = cresp.data;
    end
    if (reset) dresp.data_ok = 1'b0;
  end

  assign flush_done = flush_done_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      beat         <= '0;
      fl_set       <= '0;
      fl_way       <= '0;
      flush_done_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      flush_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            fl_set <= '0;
            fl_way <= '0;
            state  <= FLUSH_SCAN;
          end else if (dreq.valid) begin
            req_addr   <= dreq.addr;
            req_size   <= dreq.size;
            req_strobe <= dreq.strobe;
            req_data   <= dreq.data;
            state      <= dreq.addr[31] ? LOOKUP : UNCACHED;
          end
        end
        LOOKUP: begin
          if (hit) begin
            for (int b = 0; b < 8; b++)
              if (req_strobe[b]) data_mem[req_set][hit_way][req_off][8*b +: 8] <= req_data[8*b +: 8];
            if (|req_strobe) dirty_q[req_set][hit_way] <= 1'b1;
            plru_q[req_set] <= plru_touch(plru_q[req_set], hit_way);
            state <= IDLE;
          end else begin
            victim_q <= victim;
            wb_set   <= req_set;
            wb_way   <= victim;
            beat     <= '0;
            state    <= (valid_q[req_set][victim] && dirty_q[req_set][victim]) ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (cresp.ready) begin
            beat <= beat + 1'b1;
            if (cresp.last) begin
              beat  <= '0;
              state <= REFILL;
            end
          end
        end
        REFILL: begin
          if (cresp.ready) begin
            data_mem[req_set][victim_q][beat] <= cresp.data;
            beat <= beat + 1'b1;
            if (cresp.last) begin
              beat                        <= '0;
              valid_q[req_set][victim_q]  <= 1'b1;
              dirty_q[req_set][victim_q]  <= 1'b0;
              tag_mem[req_set][victim_q]  <= req_tag;
              state                       <= LOOKUP;
            end
          end
        end
        UNCACHED: begin
          if (cresp.ready && cresp.last) state <= IDLE;
        end
        FLUSH_SCAN: begin
          valid_q[fl_set][fl_way] <= 1'b0;
          if (valid_q[fl_set][fl_way] && dirty_q[fl_set][fl_way]) begin
            dirty_q[fl_set][fl_way] <= 1'b0;
            wb_set <= fl_set;
            wb_way <= fl_way;
            beat   <= '0;
            state  <= FLUSH_WB;
          end else if (fl_last) begin
            flush_done_q <= 1'b1;
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
            state <= IDLE;
          end else begin
            fl_set <= fl_set_nx;
            fl_way <= fl_way_nx;
          end
        end
        FLUSH_WB: begin
          if (cresp.ready) begin
            beat <= beat + 1'b1;
            if (cresp.last) begin
              beat <= '0;
              if (fl_last) begin
                flush_done_q <= 1'b1;
                for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
                state <= IDLE;
              end else begin
                fl_set <= fl_set_nx;
                fl_way <= fl_way_nx;
                state  <= FLUSH_SCAN;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: a stalling memory slave with a sparse memory model,
// a scoreboard of expected CPU read data, and a log of completed memory bursts.
module tb_dcache_assoc;
  import dcache_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       flush_req;
  logic       flush_done;

  dcache_assoc #(.WORDS_PER_LINE(16), .WAYS(4), .SETS(8)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp),
    .creq(creq), .cresp(cresp), .flush_req(flush_req), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    int          beats;
  } burst_t;

  int          errors = 0;
  int          checks = 0;
  int          rd_beats;
  logic [63:0] mem [logic [31:0]];
  burst_t      log_q[$];
  logic [63:0] exp_q[$];
  bit          chk_q[$];

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {~a, a};
  endfunction

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory slave: decides ready on the falling edge so the DUT consumes it on the next rise.
  initial begin : slave
    int          beat;
    logic [31:0] a;
    logic [63:0] w;
    beat     = 0;
    rd_beats = 0;
    cresp    = '0;
    forever begin
      @(negedge clk);
      cresp = '0;
      if (reset || !creq.valid) beat = 0;
      else if ($urandom_range(0, 3) != 0) begin
        a = (creq.burst == BURST_INCR) ? creq.addr + 32'(beat * 8) : creq.addr;
        a[2:0] = 3'b000;
        if (creq.is_write) begin
          w = mem_rd(a);
          for (int b = 0; b < 8; b++) if (creq.strobe[b]) w[8*b +: 8] = creq.data[8*b +: 8];
          mem[a] = w;
        end else rd_beats++;
        cresp.ready = 1'b1;
        cresp.data  = mem_rd(a);
        cresp.last  = (beat == int'(creq.len));
        if (cresp.last) begin
          log_q.push_back('{creq.addr, creq.is_write, creq.len, creq.burst, creq.size, beat + 1});
          beat = 0;
        end else beat++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic access(input logic [31:0] addr, input logic [7:0] strobe, input logic [63:0] wdata,
                        input bit chk, input logic [63:0] exp, output int lat);
    int n;
    logic [63:0] e;
    bit c;
    dreq.valid  = 1'b1;
    dreq.addr   = addr;
    dreq.size   = MSIZE8;
    dreq.strobe = strobe;
    dreq.data   = wdata;
    n = 0;
    while (!dresp.addr_ok && n < 200) begin step(); n++; end
    check("addr_ok_wait", 64'(dresp.addr_ok), 64'd1);
    exp_q.push_back(exp);
    chk_q.push_back(chk);
    step();
    dreq.valid  = 1'b0;
    dreq.addr   = $urandom;
    dreq.strobe = 8'($urandom);
    dreq.data   = {$urandom, $urandom};
    lat = 1;
    while (!dresp.data_ok && lat < 2000) begin step(); lat++; end
    check("data_ok_wait", 64'(dresp.data_ok), 64'd1);
    e = exp_q.pop_front();
    c = chk_q.pop_front();
    if (c) check("rdata", dresp.data, e);
    step();
  endtask

  task automatic check_burst(input string tag, input logic [31:0] addr, input logic we,
                             input logic [3:0] len, input logic [1:0] burst, input int beats);
    burst_t b;
    check({tag, "_present"}, 64'(log_q.size() != 0), 64'd1);
    if (log_q.size() != 0) begin
      b = log_q.pop_front();
      check({tag, "_addr"}, 64'(b.addr), 64'(addr));
      check({tag, "_we"}, 64'(b.we), 64'(we));
      check({tag, "_len"}, 64'(b.len), 64'(len));
      check({tag, "_burst"}, 64'(b.burst), 64'(burst));
      check({tag, "_size"}, 64'(b.size), 64'(MSIZE8));
      check({tag, "_beats"}, 64'(b.beats), 64'(beats));
    end
  endtask

  task automatic flush(output int pulses);
    int n;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    pulses = 0;
    n = 0;
    while (!flush_done && n < 4000) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      if (flush_done) pulses++;
      step();
    end
  endtask

  initial begin : main
    int          lat, p, n;
    logic [63:0] merged;
    reset     = 1'b1;
    flush_req = 1'b0;
    dreq      = '0;
    repeat (2) step();
    check("rst_addr_ok", 64'(dresp.addr_ok), 64'd0);
    check("rst_data_ok", 64'(dresp.data_ok), 64'd0);
    check("rst_creq_valid", 64'(creq.valid), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    reset = 1'b0;
    step();
    check("post_rst_addr_ok", 64'(dresp.addr_ok), 64'd1);
    check("post_rst_creq_valid", 64'(creq.valid), 64'd0);

    // cold read miss, then a hit in the same line
    log_q.delete();
    access(32'h8000_0040, 8'h00, '0, 1, pat(32'h8000_0040), lat);
    check("cold_miss_lat", 64'(lat > 1), 64'd1);
    check("cold_nbursts", 64'(log_q.size()), 64'd1);
    check_burst("cold_refill", 32'h8000_0000, 1'b0, MLEN16, BURST_INCR, 16);
    access(32'h8000_0048, 8'h00, '0, 1, pat(32'h8000_0048), lat);
    check("hit_lat", 64'(lat), 64'd1);
    check("hit_nbursts", 64'(log_q.size()), 64'd0);

    // partial-strobe write hit
    access(32'h8000_0048, 8'h0F, 64'h1122_3344_5566_7788, 0, '0, lat);
    check("whit_lat", 64'(lat), 64'd1);
    merged = pat(32'h8000_0048);
    merged[31:0] = 32'h5566_7788;
    access(32'h8000_0048, 8'h00, '0, 1, merged, lat);

    // fill ways 1..3 of set 0 dirty; PLRU then points at way 0 (line 0x8000_0000)
    access(32'h8000_0400, 8'hFF, 64'hD1D1_0000_0000_0001, 0, '0, lat);
    access(32'h8000_0800, 8'hFF, 64'hD2D2_0000_0000_0002, 0, '0, lat);
    access(32'h8000_0C00, 8'hFF, 64'hD3D3_0000_0000_0003, 0, '0, lat);
    log_q.delete();
    access(32'h8000_1000, 8'h00, '0, 1, pat(32'h8000_1000), lat);
    check("evict_nbursts", 64'(log_q.size()), 64'd2);
    check_burst("evict_wb", 32'h8000_0000, 1'b1, MLEN16, BURST_INCR, 16);
    check_burst("evict_refill", 32'h8000_1000, 1'b0, MLEN16, BURST_INCR, 16);
    check("evict_mem_word", mem_rd(32'h8000_0048), merged);
    access(32'h8000_0048, 8'h00, '0, 1, merged, lat);
    check("evicted_miss_lat", 64'(lat > 1), 64'd1);

    // uncached write and read-back
    log_q.delete();
    access(32'h1000_0000, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF, 0, '0, lat);
    check("unc_nbursts", 64'(log_q.size()), 64'd1);
    check_burst("unc_wr", 32'h1000_0000, 1'b1, MLEN1, BURST_FIXED, 1);
    check("unc_mem", mem_rd(32'h1000_0000), 64'hCAFE_F00D_DEAD_BEEF);
    access(32'h1000_0000, 8'h00, '0, 1, 64'hCAFE_F00D_DEAD_BEEF, lat);
    log_q.delete();
    access(32'h8000_1000, 8'h00, '0, 1, pat(32'h8000_1000), lat);
    check("unc_nochange_hit_lat", 64'(lat), 64'd1);

    // flush: clean everything, then two dirty lines give exactly two write bursts
    flush(p);
    check("flush1_pulses", 64'(p), 64'd1);
    access(32'h8000_0080, 8'hFF, 64'hE1E1_E1E1_0000_0080, 0, '0, lat);
    access(32'h8000_0100, 8'hFF, 64'hE2E2_E2E2_0000_0100, 0, '0, lat);
    log_q.delete();
    flush(p);
    check("flush2_pulses", 64'(p), 64'd1);
    check("flush2_nbursts", 64'(log_q.size()), 64'd2);
    check_burst("flush_wb0", 32'h8000_0080, 1'b1, MLEN16, BURST_INCR, 16);
    check_burst("flush_wb1", 32'h8000_0100, 1'b1, MLEN16, BURST_INCR, 16);
    check("flush_mem0", mem_rd(32'h8000_0080), 64'hE1E1_E1E1_0000_0080);
    access(32'h8000_0080, 8'h00, '0, 1, 64'hE1E1_E1E1_0000_0080, lat);
    check("flushed0_miss_lat", 64'(lat > 1), 64'd1);
    access(32'h8000_0100, 8'h00, '0, 1, 64'hE2E2_E2E2_0000_0100, lat);
    check("flushed1_miss_lat", 64'(lat > 1), 64'd1);

    // reset in the middle of a refill burst
    access(32'h8000_0300, 8'h00, '0, 1, pat(32'h8000_0300), lat);
    access(32'h8000_0300, 8'h00, '0, 1, pat(32'h8000_0300), lat);
    check("pre_rst_hit_lat", 64'(lat), 64'd1);
    rd_beats    = 0;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h8000_0200;
    dreq.strobe = 8'h00;
    n = 0;
    while (!dresp.addr_ok && n < 200) begin step(); n++; end
    step();
    dreq.valid = 1'b0;
    n = 0;
    while (rd_beats < 5 && n < 500) begin step(); n++; end
    check("mid_refill_beats", 64'(rd_beats), 64'd5);
    reset = 1'b1;
    step();
    check("mid_rst_creq_valid", 64'(creq.valid), 64'd0);
    check("mid_rst_data_ok", 64'(dresp.data_ok), 64'd0);
    reset = 1'b0;
    step();
    check("mid_rst_addr_ok", 64'(dresp.addr_ok), 64'd1);
    access(32'h8000_0300, 8'h00, '0, 1, pat(32'h8000_0300), lat);
    check("post_rst_miss_lat", 64'(lat > 1), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
